// File: rtl/bram_unaligned_lanes_pkg.sv
// Shared types and address helpers for the unaligned byte-lane RAM.
// Byte address A maps to lane A mod LANES, row (A / LANES) mod DEPTH.
package bram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  function automatic int unsigned lane_of(input int unsigned addr, input int unsigned lanes);
    return addr % lanes;
  endfunction

  function automatic int unsigned row_of(input int unsigned addr, input int unsigned lanes,
                                         input int unsigned depth);
    return (addr / lanes) % depth;
  endfunction

endpackage

// File: rtl/bram_unaligned_lanes_if.sv
// Load/store request and response bus of the unaligned byte-lane RAM.
// Reads return one cycle after acceptance; busy drops requests, nothing is queued.
interface bram_unaligned_lanes_if #(
  parameter int LANES = 4,
  parameter int DEPTH = 512
);
  localparam int ADDR_W = $clog2(LANES * DEPTH);

  logic [ADDR_W-1:0]  raddr;
  logic               rden;
  logic [ADDR_W-1:0]  waddr;
  logic [8*LANES-1:0] wdata;
  logic [LANES-1:0]   wmask;
  logic               wren;
  logic [8*LANES-1:0] rdata;
  logic               rvalid;
  logic               busy;

  modport master (
    output raddr, rden, waddr, wdata, wmask, wren,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  raddr, rden, waddr, wdata, wmask, wren,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/bram_unaligned_lanes_lane.sv
// One DEPTH x 8 byte lane, 1R1W, registered read with write-first bypass.
// Latency 1; the read register holds its value when no read is issued.
module bram_lane #(
  parameter int DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [7:0]               o_rdata
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (!rst_n)    r_rdata <= 8'h00;
    else if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/bram_unaligned_lanes.sv
// Byte-addressed RAM with unaligned LANES-byte accesses over LANES byte lanes.
// Read latency 1; requests are dropped while the post-reset clear runs (busy).
module bram_unaligned_lanes
  import bram_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int DEPTH          = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clock,
  input logic rst_n,
  bram_unaligned_lanes_if.slave bus
);
  localparam int ADDR_W = $clog2(LANES * DEPTH);
  localparam int LANE_W = $clog2(LANES);
  localparam int ROW_W  = $clog2(DEPTH);
  localparam logic [0:0] S_CLEAR = CLEAR;
  localparam logic [0:0] S_IDLE  = IDLE;

  logic [0:0]        r_state;
  logic [ROW_W-1:0]  r_row;
  logic              r_rvalid;
  logic [LANE_W-1:0] r_rot;

  logic [ADDR_W-1:0] w_waddr, w_raddr;
  logic [LANE_W-1:0] w_woff, w_roff;
  logic [ROW_W-1:0]  w_wbase, w_rbase;
  logic              w_busy, w_rd_acc;
  logic [LANES-1:0]  w_we, w_re;
  logic [LANE_W-1:0] w_widx [LANES];
  logic [ROW_W-1:0]  w_wrow [LANES];
  logic [ROW_W-1:0]  w_rrow [LANES];
  logic [7:0]        w_wdat [LANES];
  logic [7:0]        w_q    [LANES];
  logic [8*LANES-1:0] w_rdata;

  assign w_waddr  = bus.waddr;
  assign w_raddr  = bus.raddr;
  assign w_woff   = LANE_W'(lane_of(32'(w_waddr), LANES));
  assign w_roff   = LANE_W'(lane_of(32'(w_raddr), LANES));
  assign w_wbase  = ROW_W'(row_of(32'(w_waddr), LANES, DEPTH));
  assign w_rbase  = ROW_W'(row_of(32'(w_raddr), LANES, DEPTH));
  assign w_busy   = (r_state == S_CLEAR);
  assign w_rd_acc = bus.rden && !w_busy;

  // Lanes below the start offset belong to the next row; the +1 wraps at the top row.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_widx[l] = LANE_W'(l) - w_woff;
      w_we[l]   = w_busy || (bus.wren && bus.wmask[w_widx[l]]);
      w_wrow[l] = w_busy ? r_row :
                  ((LANE_W'(l) < w_woff) ? w_wbase + ROW_W'(1) : w_wbase);
      w_wdat[l] = w_busy ? 8'h00 : bus.wdata[8*w_widx[l] +: 8];
      w_re[l]   = w_rd_acc;
      w_rrow[l] = (LANE_W'(l) < w_roff) ? w_rbase + ROW_W'(1) : w_rbase;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bram_lane #(.DEPTH(DEPTH)) u_lane (
      .clock   (clock),
      .rst_n   (rst_n),
      .i_we    (w_we[g]),
      .i_waddr (w_wrow[g]),
      .i_wdata (w_wdat[g]),
      .i_re    (w_re[g]),
      .i_raddr (w_rrow[g]),
      .o_rdata (w_q[g])
    );
  end

  // Lane registers hold raw lane order; rotate back using the offset of the last accepted read.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_rdata[8*k +: 8] = w_q[LANE_W'(k) + r_rot];
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state  <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_row    <= '0;
      r_rvalid <= 1'b0;
      r_rot    <= '0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rot <= w_roff;
      if (r_state == S_CLEAR) begin
        r_row <= r_row + ROW_W'(1);
        if (r_row == ROW_W'(DEPTH - 1)) r_state <= S_IDLE;
      end
    end
  end

  assign bus.rdata  = w_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = w_busy;
endmodule

// File: tb/tb_bram_unaligned_lanes.sv
// Directed bench for bram_unaligned_lanes (LANES=4, DEPTH=512, clear on reset).
// Expected read data is queued at issue and popped when rvalid is sampled.
module tb_bram_unaligned_lanes;
  localparam int LANES = 4;
  localparam int DEPTH = 512;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] last_rd = 32'h0;

  always #5 clock = ~clock;

  bram_unaligned_lanes_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

  bram_unaligned_lanes #(.LANES(LANES), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag);
    logic [31:0] e;
    chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk(tag, bus.rdata, e);
    last_rd = e;
  endtask

  task automatic rd(input logic [10:0] a, input logic [31:0] exp, input string tag);
    bus.raddr = a;
    bus.rden  = 1'b1;
    sb.push_back(exp);
    tick();
    bus.rden  = 1'b0;
    check_read(tag);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.waddr = a;
    bus.wdata = d;
    bus.wmask = m;
    bus.wren  = 1'b1;
    tick();
    bus.wren  = 1'b0;
  endtask

  task automatic wr_rd(input logic [10:0] wa, input logic [31:0] d, input logic [3:0] m,
                       input logic [10:0] ra, input logic [31:0] exp, input string tag);
    bus.waddr = wa;
    bus.wdata = d;
    bus.wmask = m;
    bus.wren  = 1'b1;
    bus.raddr = ra;
    bus.rden  = 1'b1;
    sb.push_back(exp);
    tick();
    bus.wren  = 1'b0;
    bus.rden  = 1'b0;
    check_read(tag);
  endtask

  // Holds rden high through the clear and counts busy cycles after reset release.
  task automatic count_clear(input int preset, output int cnt, output logic seen_rv);
    cnt     = preset;
    seen_rv = 1'b0;
    bus.raddr = 11'h000;
    bus.rden  = 1'b1;
    while (bus.busy && cnt < 2000) begin
      tick();
      cnt++;
      if (bus.busy && bus.rvalid) seen_rv = 1'b1;
    end
    bus.rden = 1'b0;
  endtask

  initial begin
    int   cnt;
    logic seen_rv;
    bus.raddr = '0; bus.rden = 1'b0;
    bus.waddr = '0; bus.wdata = '0; bus.wmask = '0; bus.wren = 1'b0;

    tick(); tick(); tick();
    chk("reset_busy",   {31'b0, bus.busy},   32'd1);
    chk("reset_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("reset_rdata",  bus.rdata,           32'h0);

    rst_n = 1'b1;
    count_clear(0, cnt, seen_rv);
    chk("clear_cycles", cnt, 32'd512);
    chk("clear_no_rvalid", {31'b0, seen_rv}, 32'd0);
    chk("clear_rdata_held", bus.rdata, 32'h0);

    rd(11'h000, 32'h0000_0000, "rd_zero");

    wr(11'h010, 32'h4433_2211, 4'hF);
    wr(11'h014, 32'h8877_6655, 4'hF);
    rd(11'h010, 32'h4433_2211, "rd_aligned");
    rd(11'h011, 32'h5544_3322, "rd_unaligned1");
    rd(11'h013, 32'h7766_5544, "rd_unaligned3");

    tick();
    chk("idle_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("idle_hold",   bus.rdata,           last_rd);

    wr(11'h011, 32'hAABB_CCDD, 4'b0101);
    rd(11'h010, 32'hBB33_DD11, "rd_masked");
    wr(11'h010, 32'hFFFF_FFFF, 4'b0000);
    rd(11'h010, 32'hBB33_DD11, "rd_mask_zero");

    wr(11'h7FE, 32'hDEAD_BEEF, 4'hF);
    rd(11'h7FE, 32'hDEAD_BEEF, "rd_wrap_top");
    rd(11'h7FF, 32'h00DE_ADBE, "rd_wrap_7ff");
    rd(11'h000, 32'h0000_DEAD, "rd_wrap_0");

    wr_rd(11'h021, 32'h1122_3344, 4'hF,    11'h020, 32'h2233_4400, "coll_full");
    rd(11'h020, 32'h2233_4400, "coll_full_after");
    wr_rd(11'h031, 32'h1122_3344, 4'b0010, 11'h030, 32'h0033_0000, "coll_mask");
    wr_rd(11'h002, 32'h0102_0304, 4'hF,    11'h020, 32'h2233_4400, "no_coll");

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_clear(0, cnt, seen_rv);
    chk("clear2_cycles", cnt, 32'd512);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rst_n = 1'b0;
    bus.rden = 1'b1;
    tick();
    chk("midclear_busy_in_reset", {31'b0, bus.busy},   32'd1);
    chk("midclear_rvalid_reset",  {31'b0, bus.rvalid}, 32'd0);
    rst_n = 1'b1;
    count_clear(0, cnt, seen_rv);
    chk("midclear_cycles", cnt, 32'd512);
    chk("midclear_no_rvalid", {31'b0, seen_rv}, 32'd0);
    rd(11'h010, 32'h0000_0000, "rd_after_reclear");
    rd(11'h7FE, 32'h0000_0000, "rd_after_reclear_top");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
